// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, FSM states and
// instruction field positions.
package cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_SLTU  = 4'h6;
    localparam logic [3:0] OP_LDI   = 4'h7;
    localparam logic [3:0] OP_LD    = 4'h8;
    localparam logic [3:0] OP_ST    = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_BEQZ  = 4'hB;
    localparam logic [3:0] OP_JR    = 4'hC;
    localparam logic [3:0] OP_ILL_D = 4'hD;
    localparam logic [3:0] OP_ILL_E = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Opcodes whose EXEC step writes the ALU result to rd.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
               (op == OP_XOR) || (op == OP_SLTU) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 8-entry register file: two asynchronous read ports, one synchronous write
// port, optional hardwired-zero r0.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        i_ra1,
    input  logic [2:0]        i_ra2,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2,
    input  logic              i_we,
    input  logic [2:0]        i_wa,
    input  logic [DATA_W-1:0] i_wd
);

    logic [DATA_W-1:0] r_regs [8];
    logic              w_wr_ok;

    assign w_wr_ok = i_we && !(R0_ZERO && (i_wa == 3'd0));

    // NOTE: only eight words, so the whole array takes the async clear;
    // larger memories would be left unreset to map onto RAM macros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // No write-through: a value written this cycle is visible next cycle.
    assign o_rd1 = (R0_ZERO && (i_ra1 == 3'd0)) ? '0 : r_regs[i_ra1];
    assign o_rd2 = (R0_ZERO && (i_ra2 == 3'd0)) ? '0 : r_regs[i_ra2];

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle 16-bit-encoded CPU core sharing one req/ready memory bus for
// instruction fetch and data access.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter bit              R0_ZERO  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_illegal;

    logic [3:0]        w_op;
    logic [2:0]        w_rd;
    logic [2:0]        w_rs1;
    logic [2:0]        w_rs2;
    logic [2:0]        w_ra2;
    logic [7:0]        w_imm;
    logic [15:0]       w_instr;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [DATA_W-1:0] w_imm_data;
    logic [ADDR_W-1:0] w_imm_zext;
    logic [ADDR_W-1:0] w_imm_sext;
    logic [ADDR_W-1:0] w_a_addr;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [DATA_W-1:0] w_alu;

    logic              w_req;
    logic              w_we;
    logic              w_retire;
    logic              w_rf_we;
    logic [DATA_W-1:0] w_rf_wd;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_ld_ir;
    logic              w_ld_ab;
    logic              w_set_ill;

    assign w_op  = r_ir[OP_MSB:OP_LSB];
    assign w_rd  = r_ir[RD_MSB:RD_LSB];
    assign w_rs1 = r_ir[RS1_MSB:RS1_LSB];
    assign w_rs2 = r_ir[RS2_MSB:RS2_LSB];
    assign w_imm = r_ir[IMM_MSB:IMM_LSB];

    // Second read port doubles as the store-data / branch-test port.
    assign w_ra2 = ((w_op == OP_ST) || (w_op == OP_BEQZ)) ? w_rd : w_rs2;

    assign w_imm_data = {{(DATA_W-8){1'b0}}, w_imm};
    assign w_imm_zext = {{(ADDR_W-8){1'b0}}, w_imm};
    assign w_imm_sext = {{(ADDR_W-8){w_imm[7]}}, w_imm};
    assign w_pc_inc   = r_pc + 1'b1;

    generate
        if (DATA_W >= ADDR_W) begin : g_addr_trunc
            assign w_a_addr = r_a[ADDR_W-1:0];
        end else begin : g_addr_zext
            assign w_a_addr = {{(ADDR_W-DATA_W){1'b0}}, r_a};
        end
        if (DATA_W >= 16) begin : g_ir_trunc
            assign w_instr = mem_rdata[15:0];
        end else begin : g_ir_zext
            assign w_instr = {{(16-DATA_W){1'b0}}, mem_rdata};
        end
    endgenerate

    cpu_regfile #(
        .DATA_W  (DATA_W),
        .R0_ZERO (R0_ZERO)
    ) u_regfile (
        .clk   (clk),
        .rst_n (reset),
        .i_ra1 (w_rs1),
        .i_ra2 (w_ra2),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2),
        .i_we  (w_rf_we),
        .i_wa  (w_rd),
        .i_wd  (w_rf_wd)
    );

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = r_a + r_b;
            OP_SUB:  w_alu = r_a - r_b;
            OP_AND:  w_alu = r_a & r_b;
            OP_OR:   w_alu = r_a | r_b;
            OP_XOR:  w_alu = r_a ^ r_b;
            OP_SLTU: w_alu[0] = (r_a < r_b);
            OP_LDI:  w_alu = w_imm_data;
            default: w_alu = '0;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        w_next    = r_state;
        w_req     = 1'b0;
        w_we      = 1'b0;
        w_retire  = 1'b0;
        w_rf_we   = 1'b0;
        w_rf_wd   = w_alu;
        w_pc_next = r_pc;
        w_ld_ir   = 1'b0;
        w_ld_ab   = 1'b0;
        w_set_ill = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_req = 1'b1;
                if (mem_ready) begin
                    w_ld_ir = 1'b1;
                    w_next  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_ld_ab = 1'b1;
                w_next  = ST_EXEC;
            end
            ST_EXEC: begin
                w_retire  = 1'b1;
                w_next    = ST_FETCH;
                w_pc_next = w_pc_inc;
                if (is_alu_op(w_op)) begin
                    w_rf_we = 1'b1;
                end else begin
                    case (w_op)
                        OP_LD, OP_ST: begin
                            w_retire  = 1'b0;
                            w_pc_next = r_pc;
                            w_next    = ST_MEM;
                        end
                        OP_JMP:  w_pc_next = w_imm_zext;
                        OP_BEQZ: if (r_b == '0) w_pc_next = r_pc + w_imm_sext;
                        OP_JR:   w_pc_next = w_a_addr;
                        OP_HALT: begin
                            w_pc_next = r_pc;
                            w_next    = ST_HALT;
                        end
                        OP_ILL_D, OP_ILL_E: w_set_ill = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_MEM: begin
                w_req = 1'b1;
                w_we  = (w_op == OP_ST);
                if (mem_ready) begin
                    w_rf_we   = (w_op == OP_LD);
                    w_rf_wd   = mem_rdata;
                    w_pc_next = w_pc_inc;
                    w_retire  = 1'b1;
                    w_next    = ST_FETCH;
                end
            end
            ST_HALT: ;
            default: w_next = ST_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            if (w_ld_ir) begin
                r_ir <= w_instr;
            end
            if (w_ld_ab) begin
                r_a <= w_rd1;
                r_b <= w_rd2;
            end
            if (w_set_ill) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // NOTE: the state register already sits in FETCH during reset, so the
    // request is gated by reset directly; this also drops it mid-transfer.
    assign mem_req   = w_req && reset;
    assign mem_we    = w_we && reset;
    assign mem_addr  = (r_state == ST_MEM) ? w_a_addr : r_pc;
    assign mem_wdata = r_b;
    assign pc        = r_pc;
    assign retire    = w_retire;
    assign halted    = (r_state == ST_HALT);
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Randomized bench for multicycle_cpu: an instruction-level reference model
// predicts bus traffic, PC flow, flags and per-instruction latency.
module tb_multicycle_cpu;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam bit R0Z = 1'b1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] pc;
    logic          retire;
    logic          halted;
    logic          illegal;

    always #5 clk = ~clk;

    multicycle_cpu #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .RESET_PC (16'h0000),
        .R0_ZERO  (R0Z)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .pc        (pc),
        .retire    (retire),
        .halted    (halted),
        .illegal   (illegal)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
    } xfer_t;

    logic [15:0] tb_mem [65536];
    logic [15:0] m_mem  [65536];
    logic [15:0] m_reg  [8];
    logic [15:0] m_pc;
    bit          m_ill;
    bit          m_halt;
    xfer_t       xq[$];
    xfer_t       st_log[$];
    int          ret_cyc[$];
    int          total = 0;
    int          bad = 0;

    assign mem_rdata = tb_mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rv(input logic [2:0] i);
        return (R0Z && i == 3'd0) ? 16'h0 : m_reg[i];
    endfunction

    task automatic m_wr(input logic [2:0] i, input logic [15:0] v);
        if (!(R0Z && i == 3'd0)) m_reg[i] = v;
    endtask

    function automatic logic [15:0] rand_instr();
        int          r;
        logic [15:0] w;
        r = $urandom_range(0, 99);
        w = 16'($urandom);
        if (r < 2)       w[15:12] = 4'hF;
        else if (r < 4)  w[15:12] = (r == 2) ? 4'hD : 4'hE;
        else if (r < 8)  begin w[15:12] = 4'hA; w[7:6] = 2'b00; end
        else if (r < 14) begin w[15:12] = 4'hB; w[7:0] = 8'($urandom_range(0, 8) - 4); end
        else if (r < 17) w[15:12] = 4'hC;
        else if (r < 30) w[15:12] = 4'h7;
        else if (r < 40) w[15:12] = 4'h8;
        else if (r < 50) w[15:12] = 4'h9;
        else if (r < 52) w[15:12] = 4'h0;
        else             w[15:12] = 4'($urandom_range(1, 6));
        return w;
    endfunction

    task automatic fill_mem(input bit code);
        logic [15:0] v;
        for (int i = 0; i < 65536; i++) begin
            v = (code && i < 256) ? rand_instr() : 16'($urandom);
            tb_mem[i] = v;
            m_mem[i]  = v;
        end
    endtask

    task automatic put(input logic [15:0] a, input logic [15:0] v);
        tb_mem[a] = v;
        m_mem[a]  = v;
    endtask

    // Holds reset for two cycles, checks the reset outputs, then releases
    // reset on a falling edge so the caller samples the first FETCH cycle.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_rst_req"}, mem_req, 1'b0);
        check({tag, "_rst_we"}, mem_we, 1'b0);
        check({tag, "_rst_pc"}, pc, 16'h0);
        check({tag, "_rst_addr"}, mem_addr, 16'h0);
        check({tag, "_rst_wdata"}, mem_wdata, 16'h0);
        check({tag, "_rst_flags"}, {retire, halted, illegal}, 3'b000);
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
        m_pc = 16'h0;
        m_ill = 1'b0;
        m_halt = 1'b0;
        xq.delete();
        st_log.delete();
        ret_cyc.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic model_retire(input int cyc, input int waits);
        logic [15:0] ins, a, b, c;
        logic [3:0]  op;
        logic [2:0]  rd, rs1, rs2;
        logic [7:0]  imm;
        bit          memop;
        xfer_t       x;
        ins = m_mem[m_pc];
        op = ins[15:12]; rd = ins[11:9]; rs1 = ins[8:6]; rs2 = ins[5:3]; imm = ins[7:0];
        memop = (op == 4'h8) || (op == 4'h9);
        a = rv(rs1); b = rv(rs2); c = rv(rd);
        check("pc_at_retire", pc, m_pc);
        check("illegal_flag", illegal, m_ill);
        check("latency", cyc, (memop ? 4 : 3) + waits);
        check("xfer_count", xq.size(), memop ? 2 : 1);
        if (xq.size() > 0) begin
            x = xq.pop_front();
            check("fetch_addr", x.addr, m_pc);
            check("fetch_we", x.we, 1'b0);
        end
        if (memop && xq.size() > 0) begin
            x = xq.pop_front();
            check("data_addr", x.addr, a);
            check("data_we", x.we, op == 4'h9);
            if (op == 4'h9) check("store_data", x.wdata, c);
        end
        xq.delete();
        case (op)
            4'h1: m_wr(rd, a + b);
            4'h2: m_wr(rd, a - b);
            4'h3: m_wr(rd, a & b);
            4'h4: m_wr(rd, a | b);
            4'h5: m_wr(rd, a ^ b);
            4'h6: m_wr(rd, (a < b) ? 16'h1 : 16'h0);
            4'h7: m_wr(rd, {8'h00, imm});
            4'h8: m_wr(rd, m_mem[a]);
            4'h9: m_mem[a] = c;
            default: ;
        endcase
        case (op)
            4'hA: m_pc = {8'h00, imm};
            4'hB: m_pc = (c == 16'h0) ? m_pc + {{8{imm[7]}}, imm} : m_pc + 16'h1;
            4'hC: m_pc = a;
            4'hF: m_halt = 1'b1;
            4'hD, 4'hE: begin m_ill = 1'b1; m_pc = m_pc + 16'h1; end
            default: m_pc = m_pc + 16'h1;
        endcase
    endtask

    task automatic run_prog(input int max_ret, input int wait_pct);
        int since = 0, waits = 0, nret = 0, post = 0, cycles = 0;
        int budget;
        budget = max_ret * 25 + 50;
        while (nret < max_ret && post < 4 && cycles < budget) begin
            mem_ready = ($urandom_range(0, 99) >= wait_pct);
            #1;
            cycles++;
            since++;
            if (m_halt) begin
                check("halted", halted, 1'b1);
                check("halt_req", mem_req, 1'b0);
                check("halt_pc", pc, m_pc);
                post++;
            end else begin
                if (mem_req && !mem_ready) waits++;
                if (mem_req && mem_ready) begin
                    xq.push_back('{addr: mem_addr, we: mem_we, wdata: mem_wdata});
                    if (mem_we) begin
                        tb_mem[mem_addr] = mem_wdata;
                        st_log.push_back('{addr: mem_addr, we: mem_we, wdata: mem_wdata});
                    end
                end
                if (retire) begin
                    model_retire(since, waits);
                    nret++;
                    ret_cyc.push_back(cycles);
                    since = 0;
                    waits = 0;
                end
            end
            @(negedge clk);
        end
        check("cycle_budget", cycles < budget, 1'b1);
    endtask

    task automatic mid_mem_reset();
        bit found = 1'b0;
        fill_mem(1'b0);
        put(16'h0000, 16'h7240);   // LDI r1,0x40
        put(16'h0001, 16'h9240);   // ST  [r1]=r1
        do_reset("mid");
        for (int i = 0; i < 40 && !found; i++) begin
            mem_ready = 1'b0;
            #1;
            if (mem_req && mem_we) begin
                found = 1'b1;
            end else begin
                mem_ready = 1'b1;
                @(negedge clk);
            end
        end
        check("mid_reached_mem", found, 1'b1);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("wait_req", mem_req, 1'b1);
            check("wait_addr", mem_addr, 16'h0040);
            check("wait_we", mem_we, 1'b1);
            check("wait_wdata", mem_wdata, 16'h0040);
            check("wait_retire", retire, 1'b0);
        end
        reset = 1'b0;
        #1;
        check("abort_req", mem_req, 1'b0);
        check("abort_we", mem_we, 1'b0);
        check("abort_pc", pc, 16'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("restart_req", mem_req, 1'b1);
        check("restart_addr", mem_addr, 16'h0);
        check("restart_we", mem_we, 1'b0);
    endtask

    initial begin
        // Zero-wait straight-line program: LDI/LDI/ADD/ST then HALT.
        fill_mem(1'b0);
        put(16'h0000, 16'h7205);
        put(16'h0001, 16'h7403);
        put(16'h0002, 16'h1650);
        put(16'h0003, 16'h9640);
        put(16'h0004, 16'hF000);
        do_reset("t2");
        #1;
        check("first_req", mem_req, 1'b1);
        check("first_addr", mem_addr, 16'h0);
        check("first_we", mem_we, 1'b0);
        run_prog(10, 0);
        check("t2_retires", ret_cyc.size(), 5);
        check("t2_cycles", (ret_cyc.size() > 3) ? ret_cyc[3] : 0, 13);
        check("t2_st_addr", (st_log.size() > 0) ? st_log[0].addr : 16'hDEAD, 16'h0005);
        check("t2_st_data", (st_log.size() > 0) ? st_log[0].wdata : 16'hDEAD, 16'h0008);

        // Branch / jump flow with wait states.
        fill_mem(1'b0);
        put(16'h0000, 16'h7801);
        put(16'h0001, 16'hB805);
        put(16'h0002, 16'h7800);
        put(16'h0003, 16'hB8FE);
        put(16'h0006, 16'hA0FF);
        put(16'h00FF, 16'hF000);
        do_reset("t4");
        run_prog(20, 35);
        check("t4_pc", pc, 16'h00FF);
        check("t4_halted", halted, 1'b1);

        // SUB wrap, r0 writes dropped, illegal opcode, HALT.
        fill_mem(1'b0);
        put(16'h0000, 16'h7203);
        put(16'h0001, 16'h7405);
        put(16'h0002, 16'h2250);
        put(16'h0003, 16'h9200);
        put(16'h0004, 16'h7009);
        put(16'h0005, 16'h1A00);
        put(16'h0006, 16'h9A00);
        put(16'h0007, 16'hE000);
        put(16'h0008, 16'hF000);
        do_reset("t5");
        run_prog(20, 30);
        check("t5_sub_data", (st_log.size() > 0) ? st_log[0].wdata : 16'hDEAD, 16'hFFFE);
        check("t5_r0_data", (st_log.size() > 1) ? st_log[1].wdata : 16'hDEAD, 16'h0000);
        check("t5_illegal", illegal, 1'b1);
        check("t5_halted", halted, 1'b1);
        check("t5_pc", pc, 16'h0008);

        // Random programs at several wait-state densities.
        for (int p = 0; p < 5; p++) begin
            fill_mem(1'b1);
            do_reset("rnd");
            run_prog(300, p * 15);
        end

        mid_mem_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
